fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of core_v1. Holds the program counter, requests instructions from instruction memory over a req/ack handshake, and presents one instruction (plus its PC and opcode field) to the decode stage and `main_controller`. Accepts PC redirects from the execute stage on jumps and taken branches, discarding wrong-path fetches. Supports one outstanding memory request and a one-entry output register with downstream stall.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC fetched first after reset. Bits [1:0] must be 0.
- `NOP_INST`, default 32'h0000_0013: value of `inst` while no valid instruction is held (addi x0,x0,0).

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  32  fetch address. Stable while `imem_req`=1 and `imem_ack`=0.
- `imem_ack`  in  1  memory returns `imem_rdata`. May rise in the same cycle as `imem_req` or any later cycle.
- `imem_rdata`  in  32  instruction word. Valid only when `imem_ack`=1.
- `redirect_en`  in  1  one-cycle pulse: jump or taken branch.
- `redirect_pc`  in  32  target PC. Bits [1:0] are ignored and treated as 00.
- `stall`  in  1  decode cannot accept the held instruction this cycle.
- `inst`  out  32  held instruction. `NOP_INST` when `inst_valid`=0.
- `inst_pc`  out  32  PC of `inst`.
- `opcode`  out  7  `inst[6:0]`; drives `main_controller.opcode`.
- `inst_valid`  out  1  `inst` is valid.

## Operation
- **Registers:** `pc`, `pend_pc`, `state` ∈ {FETCH, DRAIN}, `inst`, `inst_pc`, `inst_valid`, and a request-outstanding flag `busy`.
- **Consume:** an instruction is consumed when `inst_valid`=1 and `stall`=0 in the same cycle.
- **Slot free:** `slot_free` = !`inst_valid` | !`stall`.

**FETCH state**
- `imem_req` = `busy` | `slot_free`. This is combinational from `stall`. Once a request is issued, it stays asserted until ack, regardless of `stall`.
- `imem_addr` = `pc`.
- On a cycle with req=1 and ack=0: set `busy`.
- On ack with no redirect:
  - If the slot is free: `inst`←`imem_rdata`, `inst_pc`←`pc`, `inst_valid`←1, `pc`←`pc`+4, `busy`←0.
  - If the slot is not free (only possible when `busy` was set): hold the ack data in a 32-bit skid register, keep `imem_req`=0, and load the data once the slot frees.
- Otherwise, when the held instruction is consumed and no new data arrives: `inst_valid`←0.

**Redirect, in any state**
- `inst_valid`←0 and the skid register is cleared. Redirect wins over `stall`.
- If a request is outstanding and not acked this cycle: `pend_pc`←target, `state`←DRAIN.
- Otherwise (no request outstanding, or ack in the same cycle): `pc`←target, the acked data is discarded, `state` stays FETCH.

**DRAIN state**
- `imem_req`=1, `imem_addr`=old `pc`.
- On ack: discard data, `pc`←`pend_pc`, `busy`←0, `state`←FETCH.
- A new redirect during DRAIN overwrites `pend_pc`.

**Arithmetic**
- PC increment is 32-bit modulo: 32'hFFFF_FFFC+4 = 0.

**Reset** (values in the cycle after the `rst` edge)
- `pc`=`RESET_PC`, `state`=FETCH, `busy`=0.
- `inst_valid`=0, `inst`=`NOP_INST`, `inst_pc`=0, `opcode`=7'b0010011.
- `imem_req`=1, `imem_addr`=`RESET_PC`. The first request issues in the first cycle with `rst`=0.
- Reset mid-transaction abandons any outstanding request. A late ack arriving after reset must be ignored only if it arrives while `rst`=1. The memory is required to be reset together with this block.

## Timing
- **Fetch latency:** request to `inst_valid` is ack latency + 1 cycle. With same-cycle ack: `inst_valid`=1 one edge after the request.
- **Throughput:** 1 instruction/cycle with zero-wait memory and no stall.
- **Redirect penalty:**
  - No outstanding request: the target is requested in the next cycle.
  - Outstanding request: the target is requested in the cycle after the draining ack.
- **Outputs:** `inst`, `inst_pc`, `inst_valid` and `opcode` are registered. `imem_req` and `imem_addr` are combinational from registers and `stall`.

## Test plan
- **Zero-wait stream:** reset, then ack tied to req, `rdata`=addr|0x13. Required: from 2 cycles after reset, `inst_pc` = 0, 4, 8, … one per cycle; `opcode`=7'b0010011.
- **Stall:** assert `stall` for 3 cycles while `inst_pc`=8. Required: `inst`/`inst_pc` hold at 8. At most 1 further request is issued and held in the skid. After release, the sequence continues 12, 16 with no gap or duplicate.
- **Redirect, idle memory:** `redirect_en` with `redirect_pc`=0x103 while `inst_pc`=4. Required: `inst_valid`=0 the next cycle; the next `imem_addr`=0x100; the next valid `inst_pc`=0x100.
- **Redirect during outstanding request:** ack delayed 3 cycles on addr 0x20, redirect to 0x80 in the first wait cycle. Required: DRAIN holds `imem_addr`=0x20 until ack; data discarded; next request 0x80; 0x20 never appears on `inst_pc`.
- **Redirect with same-cycle ack plus stall:** redirect, ack and `stall` all in one cycle. Required: data discarded, `inst_valid`=0, next `imem_addr`=target.
- **Wrap and reset:** redirect to 0xFFFF_FFFC. Required: next `inst_pc` values are 0xFFFF_FFFC then 0. Then assert `rst` mid-wait. Required: all outputs take their reset values and the next request is to `RESET_PC`.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, runs a single-outstanding req/ack fetch to
// instruction memory, and holds one instruction for decode with stall and redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [6:0]  opcode,
  output logic        inst_valid
);

  typedef enum logic {
    FETCH,
    DRAIN
  } state_t;

  state_t      state, state_nx;
  logic [31:0] pc, pc_nx;
  logic [31:0] pend_pc, pend_pc_nx;
  logic        busy, busy_nx;
  logic [31:0] inst_nx, inst_pc_nx;
  logic        inst_valid_nx;
  logic        skid_valid, skid_valid_nx;
  logic [31:0] skid_data;
  logic        skid_load;

  logic        slot_free;
  logic        ack_fire;
  logic        outstanding;
  logic [31:0] target;

  assign opcode = inst[6:0];

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_nx      = state;
    pc_nx         = pc;
    pend_pc_nx    = pend_pc;
    busy_nx       = busy;
    inst_nx       = inst;
    inst_pc_nx    = inst_pc;
    inst_valid_nx = inst_valid;
    skid_valid_nx = skid_valid;
    skid_load     = 1'b0;

    slot_free   = !inst_valid || !stall;
    target      = redirect_pc & ~32'h3;
    imem_addr   = pc;
    // A parked skid word blocks new requests; DRAIN keeps the abandoned request alive.
    imem_req    = (state == DRAIN) || (!skid_valid && (busy || slot_free));
    ack_fire    = imem_req && imem_ack;
    outstanding = imem_req && !imem_ack;

    if (redirect_en) begin
      inst_valid_nx = 1'b0;
      inst_nx       = NOP_INST;
      skid_valid_nx = 1'b0;
      if (outstanding) begin
        pend_pc_nx = target;
        busy_nx    = 1'b1;
        state_nx   = DRAIN;
      end else begin
        pc_nx    = target;
        busy_nx  = 1'b0;
        state_nx = FETCH;
      end
    end else if (state == DRAIN) begin
      if (ack_fire) begin
        pc_nx    = pend_pc;
        busy_nx  = 1'b0;
        state_nx = FETCH;
      end else begin
        busy_nx = 1'b1;
      end
    end else begin
      if (outstanding) busy_nx = 1'b1;
      if (ack_fire) begin
        busy_nx = 1'b0;
        if (slot_free) begin
          inst_nx       = imem_rdata;
          inst_pc_nx    = pc;
          inst_valid_nx = 1'b1;
          pc_nx         = pc + 32'd4;
        end else begin
          skid_load     = 1'b1;
          skid_valid_nx = 1'b1;
        end
      end else if (skid_valid && slot_free) begin
        inst_nx       = skid_data;
        inst_pc_nx    = pc;
        inst_valid_nx = 1'b1;
        pc_nx         = pc + 32'd4;
        skid_valid_nx = 1'b0;
      end else if (inst_valid && !stall) begin
        inst_valid_nx = 1'b0;
        inst_nx       = NOP_INST;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      pend_pc    <= RESET_PC;
      busy       <= 1'b0;
      inst       <= NOP_INST;
      inst_pc    <= 32'h0;
      inst_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      state      <= state_nx;
      pc         <= pc_nx;
      pend_pc    <= pend_pc_nx;
      busy       <= busy_nx;
      inst       <= inst_nx;
      inst_pc    <= inst_pc_nx;
      inst_valid <= inst_valid_nx;
      skid_valid <= skid_valid_nx;
    end
  end

  // NOTE: skid_data is pure datapath guarded by skid_valid, so it carries no reset.
  always_ff @(posedge clk) begin
    if (skid_load) skid_data <= imem_rdata;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run scored
// against an in-order PC stream model and a memory handshake model.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        stall;
  logic [31:0] inst, inst_pc;
  logic [6:0]  opcode;
  logic        inst_valid;

  int n_cmp = 0;
  int n_bad = 0;

  // Memory model: ack after a per-request wait; one chosen address can be made slow.
  int          lat       = 0;
  logic [31:0] slow_addr = 32'h1;
  int          slow_lat  = 0;
  int          cnt       = 0;
  int          tgt       = 0;

  fetch_unit #(.RESET_PC(RESET_PC), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc), .stall(stall),
    .inst(inst), .inst_pc(inst_pc), .opcode(opcode), .inst_valid(inst_valid)
  );

  always #5 clk = ~clk;

  assign imem_ack   = imem_req && (cnt >= ((imem_addr == slow_addr) ? slow_lat : tgt));
  assign imem_rdata = imem_ack ? (imem_addr | 32'h13) : 32'hDEAD_BEEF;

  function automatic int pick_lat();
    return (lat >= 0) ? lat : int'($urandom_range(0, 3));
  endfunction

  always @(posedge clk) begin
    if (rst || (imem_req && imem_ack)) begin
      cnt <= 0;
      tgt <= pick_lat();
    end else if (imem_req) begin
      cnt <= cnt + 1;
    end
  end

  task automatic do_reset(input int l);
    @(negedge clk);
    rst = 1'b1; stall = 1'b0; redirect_en = 1'b0; redirect_pc = 32'h0;
    lat = l; slow_addr = 32'h1; slow_lat = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; stall = 1'b0; redirect_en = 1'b0; lat = 0; slow_addr = 32'h1;
    @(negedge clk);
    n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", inst_valid); end
    n_cmp++; if (inst !== NOP) begin n_bad++; $display("FAIL reset_inst: got %h want %h", inst, NOP); end
    n_cmp++; if (inst_pc !== 32'h0) begin n_bad++; $display("FAIL reset_inst_pc: got %h want 0", inst_pc); end
    n_cmp++; if (opcode !== 7'b0010011) begin n_bad++; $display("FAIL reset_opcode: got %b want 0010011", opcode); end
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      n_bad++; $display("FAIL reset_req: req=%b addr=%h want 1/%h", imem_req, imem_addr, RESET_PC);
    end
    @(negedge clk);
    n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL reset_ack_ignored: valid=%b want 0", inst_valid); end
    rst = 1'b0;
    #1;
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      n_bad++; $display("FAIL first_req: req=%b addr=%h want 1/%h", imem_req, imem_addr, RESET_PC);
    end
    @(negedge clk);
    n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== RESET_PC) begin
      n_bad++; $display("FAIL first_latency: valid=%b pc=%h want 1/%h", inst_valid, inst_pc, RESET_PC);
    end
  endtask

  task automatic test_stream();
    logic [31:0] e;
    do_reset(0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      e = (32'(k) * 4) | 32'h13;
      n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'(k) * 4) begin
        n_bad++; $display("FAIL stream_pc[%0d]: valid=%b pc=%h want 1/%h", k, inst_valid, inst_pc, 32'(k) * 4);
      end
      n_cmp++; if (inst !== e || opcode !== e[6:0]) begin
        n_bad++; $display("FAIL stream_inst[%0d]: inst=%h op=%h want %h/%h", k, inst, opcode, e, e[6:0]);
      end
    end
  endtask

  task automatic test_stall();
    int n_req;
    do_reset(0);
    repeat (3) @(negedge clk);
    n_cmp++; if (inst_pc !== 32'h8) begin n_bad++; $display("FAIL stall_setup: pc=%h want 8", inst_pc); end
    stall = 1'b1;
    n_req = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (imem_req && imem_ack) n_req++;
      @(negedge clk);
      n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'h8 || inst !== 32'h1B) begin
        n_bad++; $display("FAIL stall_hold[%0d]: valid=%b pc=%h inst=%h want 1/8/1b", i, inst_valid, inst_pc, inst);
      end
    end
    n_cmp++; if (n_req > 1) begin n_bad++; $display("FAIL stall_reqs: got %0d want <=1", n_req); end
    stall = 1'b0;
    @(negedge clk);
    n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'hC) begin
      n_bad++; $display("FAIL stall_release12: valid=%b pc=%h want 1/c", inst_valid, inst_pc);
    end
    @(negedge clk);
    n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'h10) begin
      n_bad++; $display("FAIL stall_release16: valid=%b pc=%h want 1/10", inst_valid, inst_pc);
    end
  endtask

  task automatic test_redirect_idle();
    do_reset(0);
    repeat (2) @(negedge clk);
    n_cmp++; if (inst_pc !== 32'h4) begin n_bad++; $display("FAIL redir_idle_setup: pc=%h want 4", inst_pc); end
    redirect_en = 1'b1; redirect_pc = 32'h103;
    @(negedge clk);
    redirect_en = 1'b0;
    n_cmp++; if (inst_valid !== 1'b0 || inst !== NOP) begin
      n_bad++; $display("FAIL redir_idle_flush: valid=%b inst=%h want 0/%h", inst_valid, inst, NOP);
    end
    #1;
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      n_bad++; $display("FAIL redir_idle_addr: req=%b addr=%h want 1/100", imem_req, imem_addr);
    end
    @(negedge clk);
    n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'h100 || inst !== 32'h113) begin
      n_bad++; $display("FAIL redir_idle_next: valid=%b pc=%h inst=%h want 1/100/113", inst_valid, inst_pc, inst);
    end
  endtask

  task automatic test_redirect_drain();
    bit found;
    bit acked;
    do_reset(0);
    slow_addr = 32'h20; slow_lat = 3;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (inst_valid && inst_pc == 32'h1C) found = 1'b1;
    end
    n_cmp++; if (!found) begin n_bad++; $display("FAIL drain_setup: pc 1c not seen, got %h", inst_pc); end
    @(negedge clk);
    redirect_en = 1'b1; redirect_pc = 32'h80;
    #1;
    n_cmp++; if (imem_req !== 1'b1 || imem_ack !== 1'b0 || imem_addr !== 32'h20) begin
      n_bad++; $display("FAIL drain_wait: req=%b ack=%b addr=%h want 1/0/20", imem_req, imem_ack, imem_addr);
    end
    @(negedge clk);
    redirect_en = 1'b0;
    acked = 1'b0;
    for (int i = 0; i < 6 && !acked; i++) begin
      #1;
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h20) begin
        n_bad++; $display("FAIL drain_hold[%0d]: req=%b addr=%h want 1/20", i, imem_req, imem_addr);
      end
      acked = imem_ack;
      @(negedge clk);
      n_cmp++; if (inst_valid !== 1'b0) begin
        n_bad++; $display("FAIL drain_discard[%0d]: valid=%b pc=%h want 0", i, inst_valid, inst_pc);
      end
    end
    n_cmp++; if (!acked) begin n_bad++; $display("FAIL drain_timeout: ack=%b want 1", acked); end
    #1;
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h80) begin
      n_bad++; $display("FAIL drain_target: req=%b addr=%h want 1/80", imem_req, imem_addr);
    end
    @(negedge clk);
    n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'h80) begin
      n_bad++; $display("FAIL drain_next: valid=%b pc=%h want 1/80", inst_valid, inst_pc);
    end
  endtask

  task automatic test_redirect_ack_stall();
    do_reset(0);
    slow_addr = 32'h8; slow_lat = 1;
    repeat (3) @(negedge clk);
    stall = 1'b1; redirect_en = 1'b1; redirect_pc = 32'h200;
    #1;
    n_cmp++; if (imem_req !== 1'b1 || imem_ack !== 1'b1) begin
      n_bad++; $display("FAIL ackstall_setup: req=%b ack=%b want 1/1", imem_req, imem_ack);
    end
    @(negedge clk);
    redirect_en = 1'b0;
    n_cmp++; if (inst_valid !== 1'b0 || inst !== NOP) begin
      n_bad++; $display("FAIL ackstall_discard: valid=%b inst=%h want 0/%h", inst_valid, inst, NOP);
    end
    #1;
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      n_bad++; $display("FAIL ackstall_target: req=%b addr=%h want 1/200", imem_req, imem_addr);
    end
    @(negedge clk);
    stall = 1'b0;
    n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'h200) begin
      n_bad++; $display("FAIL ackstall_next: valid=%b pc=%h want 1/200", inst_valid, inst_pc);
    end
  endtask

  task automatic test_wrap_reset();
    do_reset(0);
    @(negedge clk);
    redirect_en = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_en = 1'b0;
    @(negedge clk);
    n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC || opcode !== 7'h7F) begin
      n_bad++; $display("FAIL wrap_top: valid=%b pc=%h op=%h want 1/fffffffc/7f", inst_valid, inst_pc, opcode);
    end
    slow_addr = 32'h4; slow_lat = 3;
    @(negedge clk);
    n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin
      n_bad++; $display("FAIL wrap_zero: valid=%b pc=%h want 1/0", inst_valid, inst_pc);
    end
    #1;
    n_cmp++; if (imem_req !== 1'b1 || imem_ack !== 1'b0 || imem_addr !== 32'h4) begin
      n_bad++; $display("FAIL wrap_wait: req=%b ack=%b addr=%h want 1/0/4", imem_req, imem_ack, imem_addr);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (inst_valid !== 1'b0 || inst !== NOP || inst_pc !== 32'h0 || opcode !== 7'h13) begin
      n_bad++; $display("FAIL midreset_outs: valid=%b inst=%h pc=%h op=%h", inst_valid, inst, inst_pc, opcode);
    end
    rst = 1'b0;
    #1;
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      n_bad++; $display("FAIL midreset_req: req=%b addr=%h want 1/%h", imem_req, imem_addr, RESET_PC);
    end
    @(negedge clk);
    n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== RESET_PC || inst !== 32'h13) begin
      n_bad++; $display("FAIL midreset_next: valid=%b pc=%h inst=%h want 1/0/13", inst_valid, inst_pc, inst);
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc, exp_inst, hold_addr, want_addr, rtgt;
    bit hold_req, want_tgt, draining, prev_redir, consume, outst;
    int n_cons;
    do_reset(-1);
    #1;
    exp_pc = RESET_PC; hold_req = imem_req && !imem_ack; hold_addr = imem_addr;
    want_tgt = 1'b0; draining = 1'b0; prev_redir = 1'b0; n_cons = 0; want_addr = 32'h0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (prev_redir) begin
        n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL rnd_flush@%0d: valid=%b want 0", cyc, inst_valid); end
      end
      exp_inst = inst_valid ? (exp_pc | 32'h13) : NOP;
      if (inst_valid) begin
        n_cmp++; if (inst_pc !== exp_pc) begin n_bad++; $display("FAIL rnd_pc@%0d: got %h want %h", cyc, inst_pc, exp_pc); end
      end
      n_cmp++; if (inst !== exp_inst || opcode !== exp_inst[6:0]) begin
        n_bad++; $display("FAIL rnd_inst@%0d: inst=%h op=%h want %h", cyc, inst, opcode, exp_inst);
      end
      stall       = ($urandom_range(0, 99) < 30);
      redirect_en = ($urandom_range(0, 99) < 6);
      rtgt        = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                : ($urandom & 32'h0000_0FFF);
      redirect_pc = rtgt;
      #1;
      if (hold_req) begin
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== hold_addr) begin
          n_bad++; $display("FAIL rnd_hold@%0d: req=%b addr=%h want 1/%h", cyc, imem_req, imem_addr, hold_addr);
        end
      end
      if (want_tgt) begin
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== want_addr) begin
          n_bad++; $display("FAIL rnd_target@%0d: req=%b addr=%h want 1/%h", cyc, imem_req, imem_addr, want_addr);
        end
      end
      consume = inst_valid && !stall;
      outst   = imem_req && !imem_ack;
      if (consume && !redirect_en) n_cons++;
      if (redirect_en) begin
        exp_pc    = rtgt & ~32'h3;
        want_addr = exp_pc;
        draining  = outst;
        want_tgt  = !outst;
      end else begin
        if (consume) exp_pc = exp_pc + 32'd4;
        want_tgt = draining && imem_ack;
        if (imem_ack) draining = 1'b0;
      end
      hold_req   = outst;
      hold_addr  = imem_addr;
      prev_redir = redirect_en;
    end
    redirect_en = 1'b0;
    stall = 1'b0;
    n_cmp++; if (n_cons < 300) begin n_bad++; $display("FAIL rnd_progress: consumed %0d want >=300", n_cons); end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_en = 1'b0; redirect_pc = 32'h0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_idle();
    test_redirect_drain();
    test_redirect_ack_stall();
    test_wrap_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
